// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Frames a 1-bit serial line (start bit 0, WIDTH data bits, stop bit 1,
//   idle high) and assembles each good frame into a parallel word held in a
//   1-deep output register with a valid/ready handshake. A stop bit sampled
//   low raises a 1-cycle frame_err pulse; a good frame that arrives while the
//   output register is full and not being accepted is dropped and raises a
//   1-cycle overrun pulse.
// Ports
//   clk        single clock, all state on posedge
//   rst        asynchronous, active-high reset
//   in         serial line, one bit per clk
//   out_data   assembled word, stable while out_valid=1
//   out_valid  word available
//   out_ready  consumer accepts word when out_valid && out_ready
//   frame_err  1-cycle pulse: stop bit sampled 0
//   overrun    1-cycle pulse: good frame dropped, output register full
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_STOP    = 2'd2,
    S_WAIT_HI = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               load;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!in) state_d = S_DATA;
        else     state_d = S_IDLE;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) state_d = S_STOP;
        else                   state_d = S_DATA;
      end
      S_STOP: begin
        // A low stop bit parks in WAIT_HI so a still-low line is not
        // mistaken for the next start bit.
        if (in) state_d = S_IDLE;
        else    state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (in) state_d = S_IDLE;
        else    state_d = S_WAIT_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    // A good stop bit loads the word if the register is empty or is being
    // drained in this same cycle.
    load = (state_q == S_STOP) && in && (!valid_q || out_ready);

    if (state_q == S_DATA) cnt_d = cnt_q + CNT_W'(1);
    else                   cnt_d = '0;

    if (state_q == S_DATA) begin
      if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], in};
      else           shift_d = {in, shift_q[WIDTH-1:1]};
    end else begin
      shift_d = shift_q;
    end

    if (load) data_d = shift_q;
    else      data_d = data_q;

    if (load)                      valid_d = 1'b1;
    else if (valid_q && out_ready) valid_d = 1'b0;
    else                           valid_d = valid_q;

    ferr_d = (state_q == S_STOP) && !in;
    ovr_d  = (state_q == S_STOP) && in && valid_q && !out_ready;
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer
//   Drives two deserializers (MSB-first and LSB-first) from one serial line
//   and one out_ready, runs directed framing/handshake scenarios and a
//   randomized frame stream checked against a word-level reference model.
module tb_serial_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_s;
  logic         ready;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in(in_s), .out_data(data_m), .out_valid(valid_m),
    .out_ready(ready), .frame_err(ferr_m), .overrun(ovr_m)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in(in_s), .out_data(data_l), .out_valid(valid_l),
    .out_ready(ready), .frame_err(ferr_l), .overrun(ovr_l)
  );

  // Bit i of a frame carrying word w: 0 = start, 1..W = data, W+1 = stop.
  function automatic logic frame_bit(input logic [W-1:0] w, input int i,
                                     input logic msb, input logic stop);
    if (i == 0) return 1'b0;
    if (i == W + 1) return stop;
    return msb ? w[W-i] : w[i-1];
  endfunction

  // Present one cycle of input, then step to just after the next edge.
  task automatic drive(input logic b, input logic r);
    in_s  = b;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_s = 1'b1; ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({valid_m, ferr_m, ovr_m, data_m, valid_l, ferr_l, ovr_l, data_l} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset: got %h want 0", {valid_m, ferr_m, ovr_m, data_m, valid_l, ferr_l, ovr_l, data_l});
    end
    rst = 1'b0;
    drive(1'b1, 1'b1);
  endtask

  task automatic test_msb_frame;
    for (int i = 0; i < W + 2; i++) begin
      drive(frame_bit(8'hA5, i, 1'b1, 1'b1), 1'b1);
      if (i < W + 1) begin
        n_checks++;
        if (valid_m !== 1'b0) begin
          n_fail++;
          $display("FAIL msb_early_valid bit %0d: got %b want 0", i, valid_m);
        end
      end
    end
    n_checks++;
    if ({valid_m, ferr_m, ovr_m, data_m} !== {3'b100, 8'hA5}) begin
      n_fail++;
      $display("FAIL msb_word: got %h want %h", {valid_m, ferr_m, ovr_m, data_m}, {3'b100, 8'hA5});
    end
    drive(1'b1, 1'b1);
    n_checks++;
    if (valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_valid_drop: got %b want 0", valid_m);
    end
  endtask

  task automatic test_lsb_frame;
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'hB8, i, 1'b0, 1'b1), 1'b1);
    n_checks++;
    if ({valid_l, data_l} !== {1'b1, 8'hB8}) begin
      n_fail++;
      $display("FAIL lsb_word: got %h want %h", {valid_l, data_l}, {1'b1, 8'hB8});
    end
    n_checks++;
    if ({valid_m, data_m} !== {1'b1, 8'h1D}) begin
      n_fail++;
      $display("FAIL lsb_stream_on_msb: got %h want %h", {valid_m, data_m}, {1'b1, 8'h1D});
    end
    drive(1'b1, 1'b1);
  endtask

  task automatic test_frame_err;
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'h5A, i, 1'b1, 1'b0), 1'b1);
    n_checks++;
    if ({valid_m, ferr_m, ovr_m} !== 3'b010) begin
      n_fail++;
      $display("FAIL ferr_pulse: got %b want 010", {valid_m, ferr_m, ovr_m});
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1);
      n_checks++;
      if ({valid_m, ferr_m, ovr_m} !== 3'b000) begin
        n_fail++;
        $display("FAIL ferr_low_hold %0d: got %b want 000", k, {valid_m, ferr_m, ovr_m});
      end
    end
    drive(1'b1, 1'b1);
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'h5A, i, 1'b1, 1'b1), 1'b1);
    n_checks++;
    if ({valid_m, ferr_m, ovr_m, data_m} !== {3'b100, 8'h5A}) begin
      n_fail++;
      $display("FAIL ferr_recover: got %h want %h", {valid_m, ferr_m, ovr_m, data_m}, {3'b100, 8'h5A});
    end
    drive(1'b1, 1'b1);
  endtask

  task automatic test_overrun;
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'h11, i, 1'b1, 1'b1), 1'b0);
    n_checks++;
    if ({valid_m, data_m} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL ovr_first: got %h want %h", {valid_m, data_m}, {1'b1, 8'h11});
    end
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'h22, i, 1'b1, 1'b1), 1'b0);
    n_checks++;
    if ({valid_m, ferr_m, ovr_m, data_m} !== {3'b101, 8'h11}) begin
      n_fail++;
      $display("FAIL ovr_pulse: got %h want %h", {valid_m, ferr_m, ovr_m, data_m}, {3'b101, 8'h11});
    end
    drive(1'b1, 1'b0);
    n_checks++;
    if ({valid_m, ovr_m, data_m} !== {2'b10, 8'h11}) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: got %h want %h", {valid_m, ovr_m, data_m}, {2'b10, 8'h11});
    end
    drive(1'b1, 1'b1);
    n_checks++;
    if (valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain: got %b want 0", valid_m);
    end
  endtask

  task automatic test_ready_in_stop;
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'h11, i, 1'b1, 1'b1), 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      drive(frame_bit(8'h22, i, 1'b1, 1'b1), (i == W + 1) ? 1'b1 : 1'b0);
      n_checks++;
      if ({valid_m, ovr_m} !== 2'b10) begin
        n_fail++;
        $display("FAIL swap_valid_held bit %0d: got %b want 10", i, {valid_m, ovr_m});
      end
    end
    n_checks++;
    if (data_m !== 8'h22) begin
      n_fail++;
      $display("FAIL swap_data: got %h want 22", data_m);
    end
    drive(1'b1, 1'b0);
    n_checks++;
    if ({valid_m, ovr_m, data_m} !== {2'b10, 8'h22}) begin
      n_fail++;
      $display("FAIL swap_no_ovr: got %h want %h", {valid_m, ovr_m, data_m}, {2'b10, 8'h22});
    end
    drive(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < W + 2; i++) drive(frame_bit(8'h3C, i, 1'b1, 1'b1), 1'b0);
    for (int i = 0; i < 5; i++) drive(frame_bit(8'hC3, i, 1'b1, 1'b1), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid_m, ferr_m, ovr_m, data_m, valid_l, ferr_l, ovr_l, data_l} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0", {valid_m, ferr_m, ovr_m, data_m, valid_l, ferr_l, ovr_l, data_l});
    end
    in_s = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < W + 2; i++) begin
      drive(frame_bit(8'hC3, i, 1'b1, 1'b1), 1'b1);
      if (i == W) begin
        n_checks++;
        if (valid_m !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_no_partial: got %b want 0", valid_m);
        end
      end
    end
    n_checks++;
    if ({valid_m, ferr_m, ovr_m, data_m} !== {3'b100, 8'hC3}) begin
      n_fail++;
      $display("FAIL reset_then_frame: got %h want %h", {valid_m, ferr_m, ovr_m, data_m}, {3'b100, 8'hC3});
    end
    drive(1'b1, 1'b1);
  endtask

  // Random frames, gaps, bad stop bits and consumer stalls. The model works
  // at the word level: each stop bit is an event that either loads, drops
  // (overrun) or flags (frame_err), against the current output-register view.
  task automatic test_random;
    logic         bit_q[$];
    int           tag_q[$];
    logic [W-1:0] word_q[$];
    logic         prev_bad;
    logic         mv, eferr, eovr, r, stop;
    logic [W-1:0] md_m, md_l, w, rev;
    int           gap, zeros;

    rst = 1'b1; in_s = 1'b1; ready = 1'b0;
    #2;
    rst = 1'b0;
    mv = 1'b0; md_m = '0; md_l = '0; prev_bad = 1'b0;

    for (int f = 0; f < 40; f++) begin
      gap = $urandom_range(0, 2);
      if (prev_bad) begin
        zeros = $urandom_range(0, 2);
        for (int k = 0; k < zeros; k++) begin
          bit_q.push_back(1'b0); tag_q.push_back(0); word_q.push_back('0);
        end
        gap = gap + 1;
      end
      for (int k = 0; k < gap; k++) begin
        bit_q.push_back(1'b1); tag_q.push_back(0); word_q.push_back('0);
      end
      w    = W'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      for (int i = 0; i <= W; i++) begin
        bit_q.push_back(frame_bit(w, i, 1'b1, stop)); tag_q.push_back(0); word_q.push_back('0);
      end
      bit_q.push_back(stop); tag_q.push_back(stop ? 1 : 2); word_q.push_back(w);
      prev_bad = !stop;
    end
    for (int k = 0; k < 3; k++) begin
      bit_q.push_back(1'b1); tag_q.push_back(0); word_q.push_back('0);
    end

    for (int idx = 0; idx < bit_q.size(); idx++) begin
      r = 1'($urandom_range(0, 1));
      eferr = 1'b0;
      eovr  = 1'b0;
      if (tag_q[idx] == 1) begin
        if (!mv || r) begin
          mv   = 1'b1;
          md_m = word_q[idx];
          for (int k = 0; k < W; k++) rev[k] = word_q[idx][W-1-k];
          md_l = rev;
        end else begin
          eovr = 1'b1;
        end
      end else begin
        if (tag_q[idx] == 2) eferr = 1'b1;
        if (mv && r) mv = 1'b0;
      end
      drive(bit_q[idx], r);
      n_checks++;
      if ({valid_m, ferr_m, ovr_m, data_m} !== {mv, eferr, eovr, md_m}) begin
        n_fail++;
        $display("FAIL rand_msb step %0d: got %h want %h", idx, {valid_m, ferr_m, ovr_m, data_m}, {mv, eferr, eovr, md_m});
      end
      n_checks++;
      if ({valid_l, ferr_l, ovr_l, data_l} !== {mv, eferr, eovr, md_l}) begin
        n_fail++;
        $display("FAIL rand_lsb step %0d: got %h want %h", idx, {valid_l, ferr_l, ovr_l, data_l}, {mv, eferr, eovr, md_l});
      end
    end
  endtask

  initial begin
    test_reset;
    test_msb_frame;
    test_lsb_frame;
    test_frame_err;
    test_overrun;
    test_ready_in_stop;
    test_reset_mid_frame;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
